nibble_serial_adder_ctrl: RTL and testbench

Multi-cycle controller that performs WIDTH-bit add/subtract by time-multiplexing a single `carry_lookahead_adder_4bit` instance, one nibble per clock, least-significant first. The inter-nibble carry is kept in a register. Operands and results are registered. A start/ready/done handshake connects the block to the ALU sequencer. It trades latency for area in narrow-datapath ALU builds.

---
 rtl/nibble_serial_adder_ctrl_if.sv | 17 +
 rtl/nibble_serial_adder_ctrl.sv | 114 +++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/nibble_serial_adder_ctrl_if.sv
// nibble_serial_adder_ctrl_if: start/ready/done handshake and operand/result bus for the serial adder
interface nibble_serial_adder_ctrl_if #(parameter int WIDTH = 16);
    logic             start;
    logic             ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             zero;
    modport master (output start, a, b, cin, sub, input ready, busy, done, sum, cout, overflow, zero);
    modport slave  (input start, a, b, cin, sub, output ready, busy, done, sum, cout, overflow, zero);
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: WIDTH-bit add/sub computed one nibble per clock on a shared 4-bit CLA
module carry_lookahead_adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout,
    output logic       g,
    output logic       p
);
    logic [3:0] gi, pi, c;
    always_comb begin
        gi = a & b;
        pi = a ^ b;
        c[0] = cin;
        c[1] = gi[0] | (pi[0] & cin);
        c[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & cin);
        c[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0]) | ((&pi[2:0]) & cin);
        g = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1]) | ((&pi[3:1]) & gi[0]);
        p = &pi;
        cout = g | (p & cin);
        sum = pi ^ c;
    end
endmodule

module nibble_serial_adder_ctrl #(parameter int WIDTH = 16) (
    input logic clk,
    input logic rst,
    nibble_serial_adder_ctrl_if.slave bus
);
    localparam int NIB = WIDTH / 4;
    localparam int IW = NIB > 1 ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic [WIDTH-1:0] opa, opb, sum_r, fsum;
    logic [IW-1:0] idx;
    logic carry, ready_r, busy_r, done_r, cout_r, ovf_r, zero_r;
    logic [3:0] nsum;
    logic ncout, cla_g_unused, cla_p_unused;
    carry_lookahead_adder_4bit cla (
        .a(opa[4*idx +: 4]),
        .b(opb[4*idx +: 4]),
        .cin(carry),
        .sum(nsum),
        .cout(ncout),
        .g(cla_g_unused),
        .p(cla_p_unused)
    );
    // the full sum as it will stand after this edge, so zero/overflow see the last nibble
    always_comb begin
        fsum = sum_r;
        fsum[4*idx +: 4] = nsum;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ready_r <= 1'b1;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            sum_r <= '0;
            cout_r <= 1'b0;
            ovf_r <= 1'b0;
            zero_r <= 1'b0;
            idx <= '0;
            carry <= 1'b0;
            opa <= '0;
            opb <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    opa <= bus.a;
                    opb <= bus.sub ? ~bus.b : bus.b;
                    carry <= bus.sub | bus.cin;
                    idx <= '0;
                    state <= RUN;
                    ready_r <= 1'b0;
                    busy_r <= 1'b1;
                end
                RUN: begin
                    sum_r <= fsum;
                    carry <= ncout;
                    idx <= idx + 1'b1;
                    if (idx == LAST) begin
                        cout_r <= ncout;
                        ovf_r <= (opa[WIDTH-1] == opb[WIDTH-1]) && (fsum[WIDTH-1] != opa[WIDTH-1]);
                        zero_r <= fsum == '0;
                        done_r <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    ready_r <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    ready_r <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end
    assign bus.ready = ready_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.sum = sum_r;
    assign bus.cout = cout_r;
    assign bus.overflow = ovf_r;
    assign bus.zero = zero_r;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl: vector table, random ops against an arithmetic model, handshake and reset sequences
module tb_nibble_serial_adder_ctrl;
    localparam int W = 16;
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    bit armed = 1'b0;
    int checks = 0;
    int errors = 0;
    vec_t tbl[8];
    vec_t hs[24];
    always #5 clk = ~clk;
    nibble_serial_adder_ctrl_if #(.WIDTH(W)) bus();
    nibble_serial_adder_ctrl #(.WIDTH(W)) dut(.clk(clk), .rst(rst), .bus(bus));

    function automatic vec_t model(logic [W-1:0] a, logic [W-1:0] b, logic cin, logic sub);
        vec_t v;
        logic [W-1:0] bb;
        logic [W:0] full;
        bb = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + (W+1)'(sub | cin);
        v.a = a;
        v.b = b;
        v.cin = cin;
        v.sub = sub;
        v.sum = full[W-1:0];
        v.cout = full[W];
        v.ovf = (a[W-1] == bb[W-1]) && (v.sum[W-1] != a[W-1]);
        v.zero = v.sum == '0;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // every sampled cycle after reset also confirms ready/busy exclusivity
    task automatic tick();
        @(posedge clk);
        #1;
        if (armed) check("ready_busy_excl", 32'({bus.ready, bus.busy}), 32'({~bus.busy, bus.busy}));
    endtask

    task automatic check_res(string tag, vec_t v);
        check({tag, "_sum"}, 32'(bus.sum), 32'(v.sum));
        check({tag, "_cout"}, 32'(bus.cout), 32'(v.cout));
        check({tag, "_ovf"}, 32'(bus.overflow), 32'(v.ovf));
        check({tag, "_zero"}, 32'(bus.zero), 32'(v.zero));
    endtask

    task automatic run_op(string tag, vec_t v);
        int n;
        check({tag, "_ready_pre"}, 32'(bus.ready), 32'd1);
        bus.a = v.a;
        bus.b = v.b;
        bus.cin = v.cin;
        bus.sub = v.sub;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.a = W'($urandom);
        bus.b = W'($urandom);
        bus.cin = 1'($urandom);
        bus.sub = 1'($urandom);
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd4);
        check_res(tag, v);
        tick();
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        check({tag, "_ready_post"}, 32'(bus.ready), 32'd1);
        check({tag, "_hold_sum"}, 32'(bus.sum), 32'(v.sum));
    endtask

    initial begin
        tbl[0] = '{16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        bus.sub = 1'b0;
        tick();
        tick();
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check_res("rst", '{16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0});
        rst = 1'b0;
        armed = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) run_op($sformatf("tbl%0d", i), tbl[i]);
        for (int i = 0; i < 40; i++)
            run_op($sformatf("rnd%0d", i), model(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom)));
        // start held high with operands changing every cycle: only ready-cycle operands count
        for (int k = 0; k < 24; k++) begin
            hs[k] = model(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
            bus.a = hs[k].a;
            bus.b = hs[k].b;
            bus.cin = hs[k].cin;
            bus.sub = hs[k].sub;
            bus.start = 1'b1;
            tick();
            check($sformatf("hs_done_k%0d", k), 32'(bus.done), 32'(k % 6 == 4));
            if (k % 6 == 4) check_res($sformatf("hs_k%0d", k), hs[k-4]);
            if (k % 6 == 5) check($sformatf("hs_hold_k%0d", k), 32'(bus.sum), 32'(hs[k-5].sum));
        end
        bus.start = 1'b0;
        tick();
        bus.a = 16'h1234;
        bus.b = 16'h0FCD;
        bus.cin = 1'b0;
        bus.sub = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_ready", 32'(bus.ready), 32'd1);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        check_res("mid_rst", '{16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0});
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("mid_rst_nodone%0d", i), 32'(bus.done), 32'd0);
        end
        run_op("after_rst", '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0});
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
